// File: rtl/ps2_scancode_fifo_pkg.sv
// Shared constants for the PS/2 scancode buffer: status register bit layout,
// register offsets and a helper that assembles the status word.
package ps2_pkg;

   localparam int STATUS_NOT_EMPTY_BIT = 31;
   localparam int STATUS_PARITY_BIT    = 30;
   localparam int STATUS_OVERFLOW_BIT  = 29;
   localparam int STATUS_FULL_BIT      = 28;
   localparam int STATUS_COUNT_LSB     = 16;

   localparam logic [7:0] PS2_STATUS_ADDR   = 8'h04;
   localparam logic [7:0] PS2_SCANCODE_ADDR = 8'h08;

   function automatic logic [31:0] pack_status(input logic       not_empty,
                                               input logic       parity,
                                               input logic       overflow,
                                               input logic       full,
                                               input logic [7:0] count);
      logic [31:0] word;
      word                                       = 32'h0000_0000;
      word[STATUS_NOT_EMPTY_BIT]                 = not_empty;
      word[STATUS_PARITY_BIT]                    = parity;
      word[STATUS_OVERFLOW_BIT]                  = overflow;
      word[STATUS_FULL_BIT]                      = full;
      word[STATUS_COUNT_LSB +: 8]                = count;
      return word;
   endfunction

endpackage

// File: rtl/ps2_scancode_fifo_sync_fifo.sv
// Generic circular-buffer FIFO with occupancy count and flush.
// A pop on an empty FIFO is ignored; a push while full only lands if a pop frees a slot.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push_s;
   logic                  do_pop_s;

   assign empty     = (count_q == '0);
   assign full      = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);
   assign dout      = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; contents are only observed through count.
   always_ff @(posedge clock) begin
      if (do_push_s && !flush) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/ps2_scancode_fifo.sv
// PS/2 scancode buffer: FIFO between the receive shifter and the CPU bus,
// with one-pop-per-access edge detect, sticky error flags and register decode.
module ps2_scancode_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  rx_scancode,
   input  logic        scancode_ready_set,
   input  logic        parity_error,
   input  logic        read,
   input  logic        write,
   input  logic        status_cs,
   input  logic        scancode_cs,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        data_out_valid
);

   logic                pop_arm_q;
   logic                overflow_q, overflow_d;
   logic                parity_q, parity_d;
   logic                sc_rd_s, st_rd_s, ctrl_wr_s, ctrl_act_s;
   logic                good_byte_s, pop_req_s;
   logic                fifo_push_s, fifo_pop_s, fifo_flush_s;
   logic [7:0]          fifo_dout_s;
   logic [DEPTH_LOG2:0] fifo_count_s;
   logic                fifo_full_s, fifo_empty_s;
   logic                unused_s;

   assign sc_rd_s     = read & scancode_cs;
   assign st_rd_s     = read & status_cs;
   assign ctrl_wr_s   = write & status_cs;
   assign ctrl_act_s  = ctrl_wr_s & (|data_in[30:28]);
   assign pop_req_s   = sc_rd_s & ~pop_arm_q;
   assign good_byte_s = scancode_ready_set & ~parity_error;

   // Control writes win over queue traffic in the same cycle.
   assign fifo_push_s  = good_byte_s & ~ctrl_act_s;
   assign fifo_pop_s   = pop_req_s & ~ctrl_act_s;
   assign fifo_flush_s = ctrl_wr_s & data_in[28];
   assign unused_s     = ^{data_in[31], data_in[27:0]};

   sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push_s),
      .pop   (fifo_pop_s),
      .flush (fifo_flush_s),
      .din   (rx_scancode),
      .dout  (fifo_dout_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // A set in the same cycle as a clear leaves the flag set.
   always_comb begin
      overflow_d = (good_byte_s & fifo_full_s & ~fifo_pop_s)
                 | (overflow_q & ~(ctrl_wr_s & data_in[29]));
      parity_d   = (scancode_ready_set & parity_error)
                 | (parity_q & ~(ctrl_wr_s & data_in[30]));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pop_arm_q  <= 1'b0;
         overflow_q <= 1'b0;
         parity_q   <= 1'b0;
      end else begin
         pop_arm_q  <= sc_rd_s;
         overflow_q <= overflow_d;
         parity_q   <= parity_d;
      end
   end

   always_comb begin
      data_out       = 32'h0000_0000;
      data_out_valid = 1'b0;
      if (reset) begin
         data_out       = 32'h0000_0000;
         data_out_valid = 1'b0;
      end else if (sc_rd_s) begin
         data_out_valid = 1'b1;
         data_out       = fifo_empty_s ? 32'h0000_0000 : {fifo_dout_s, 24'h00_0000};
      end else if (st_rd_s) begin
         data_out_valid = 1'b1;
         data_out       = pack_status(~fifo_empty_s, parity_q, overflow_q, fifo_full_s,
                                      8'(fifo_count_s));
      end else begin
         data_out       = 32'h0000_0000;
         data_out_valid = 1'b0;
      end
   end

endmodule
